vec_crossbar_nxm: RTL and testbench

Parametrised N-input, M-output registered crossbar for the vector datapath, sitting between lane sources (load unit, ALU results, feedback path) and lane consumers. Each output has a runtime-programmable source select and enable. Each output has a one-entry registered stage with valid/ready handshake. One input may fork to several outputs, and the input is consumed only when every enabled output that selects it accepts in the same cycle. Configuration is swapped atomically, only while the crossbar is drained.

---
 rtl/vec_crossbar_nxm.sv | 130 +++++++++++++
 tb/tb_vec_crossbar_nxm.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_crossbar_nxm.sv
// rtl/vec_crossbar_nxm.sv - N-input, M-output registered vector crossbar with atomic reconfiguration
//
// Each output j owns a one-entry register stage fed from the input chosen by
// its source select.  An input may fork to several outputs and is accepted
// only when every enabled output selecting it can load in the same cycle.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   in_data       NUM_INPUTS lanes, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_valid      per-input valid
//   in_ready      per-input ready (independent of in_valid)
//   out_data      registered output lanes, lane j at [j*DATA_WIDTH +: DATA_WIDTH]
//   out_valid     registered per-output valid
//   out_ready     per-output ready
//   cfg_src       requested source for output j at [j*SEL_W +: SEL_W]
//   cfg_en        requested output enable mask
//   cfg_we        configuration write request, held until cfg_ready
//   cfg_ready     configuration write accepted this cycle (crossbar drained)
//   busy          OR of out_valid

module vec_crossbar_nxm #(
    parameter int  DATA_WIDTH  = 16,
    parameter int  NUM_INPUTS  = 8,
    parameter int  NUM_OUTPUTS = 8,
    localparam int SEL_W       = $clog2(NUM_INPUTS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0]  in_data,
    input  logic [NUM_INPUTS-1:0]             in_valid,
    output logic [NUM_INPUTS-1:0]             in_ready,
    output logic [NUM_OUTPUTS*DATA_WIDTH-1:0] out_data,
    output logic [NUM_OUTPUTS-1:0]            out_valid,
    input  logic [NUM_OUTPUTS-1:0]            out_ready,
    input  logic [NUM_OUTPUTS*SEL_W-1:0]      cfg_src,
    input  logic [NUM_OUTPUTS-1:0]            cfg_en,
    input  logic                              cfg_we,
    output logic                              cfg_ready,
    output logic                              busy
);

    logic [SEL_W-1:0]      src_q [NUM_OUTPUTS];
    logic [NUM_OUTPUTS-1:0] en_q;

    // sel[j][i]: output j is enabled and sources input i
    logic [NUM_INPUTS-1:0]  sel [NUM_OUTPUTS];
    logic [NUM_OUTPUTS-1:0] can_load;
    logic [NUM_OUTPUTS-1:0] load;
    logic [DATA_WIDTH-1:0]  load_data [NUM_OUTPUTS];
    logic [NUM_INPUTS-1:0]  has_sel;
    logic [NUM_INPUTS-1:0]  blocked;
    logic [NUM_INPUTS-1:0]  fire;
    logic                   cfg_apply;

    assign busy      = |out_valid;
    assign cfg_ready = !busy;
    assign cfg_apply = cfg_we && cfg_ready;
    assign fire      = in_valid & in_ready;

    // Source values at or above NUM_INPUTS never equal any in-range index,
    // so such outputs are naturally treated as disabled.
    always_comb begin
        for (int j = 0; j < NUM_OUTPUTS; j++) begin
            can_load[j] = !out_valid[j] || out_ready[j];
            for (int i = 0; i < NUM_INPUTS; i++) begin
                sel[j][i] = en_q[j] && (src_q[j] == SEL_W'(i));
            end
        end
    end

    // An input is ready only if at least one output selects it and all of
    // them can load now; the forced zero during cfg_apply keeps the config
    // swap from racing with a transfer.
    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            has_sel[i] = 1'b0;
            blocked[i] = 1'b0;
            for (int j = 0; j < NUM_OUTPUTS; j++) begin
                if (sel[j][i]) begin
                    has_sel[i] = 1'b1;
                    if (!can_load[j]) begin
                        blocked[i] = 1'b1;
                    end
                end
            end
            in_ready[i] = has_sel[i] && !blocked[i] && !cfg_apply;
        end
    end

    // At most one input matches per output, so the last match is the only one.
    always_comb begin
        for (int j = 0; j < NUM_OUTPUTS; j++) begin
            load[j]      = 1'b0;
            load_data[j] = '0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (sel[j][i]) begin
                    load[j]      = fire[i];
                    load_data[j] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < NUM_OUTPUTS; j++) begin
                src_q[j] <= SEL_W'(j % NUM_INPUTS);
            end
            en_q      <= '1;
            out_valid <= '0;
            out_data  <= '0;
        end else begin
            if (cfg_apply) begin
                for (int j = 0; j < NUM_OUTPUTS; j++) begin
                    src_q[j] <= cfg_src[j*SEL_W +: SEL_W];
                end
                en_q <= cfg_en;
            end
            for (int j = 0; j < NUM_OUTPUTS; j++) begin
                if (load[j]) begin
                    out_valid[j]                           <= 1'b1;
                    out_data[j*DATA_WIDTH +: DATA_WIDTH]   <= load_data[j];
                end else if (out_ready[j]) begin
                    out_valid[j] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_vec_crossbar_nxm.sv
// tb/tb_vec_crossbar_nxm.sv - scoreboard testbench for vec_crossbar_nxm

module tb_vec_crossbar_nxm;

    localparam int DW = 16;
    localparam int NI = 8;
    localparam int NO = 8;
    localparam int SW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NI*DW-1:0]  in_data;
    logic [NI-1:0]     in_valid;
    logic [NI-1:0]     in_ready;
    logic [NO*DW-1:0]  out_data;
    logic [NO-1:0]     out_valid;
    logic [NO-1:0]     out_ready;
    logic [NO*SW-1:0]  cfg_src;
    logic [NO-1:0]     cfg_en;
    logic              cfg_we;
    logic              cfg_ready;
    logic              busy;

    vec_crossbar_nxm #(.DATA_WIDTH(DW), .NUM_INPUTS(NI), .NUM_OUTPUTS(NO)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .cfg_src(cfg_src), .cfg_en(cfg_en), .cfg_we(cfg_we),
        .cfg_ready(cfg_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bench-side routing model and per-output expected-data queues
    int              tb_src [NO];
    bit              tb_en  [NO];
    logic [DW-1:0]   sb_q   [NO][$];
    bit              hold   [NO];
    logic [DW-1:0]   hold_data [NO];

    function automatic logic [DW-1:0] lane(input int j);
        return out_data[j*DW +: DW];
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            for (int j = 0; j < NO; j++) begin
                sb_q[j].delete();
                tb_src[j] = j;
                tb_en[j]  = 1'b1;
                hold[j]   = 1'b0;
            end
        end else begin
            for (int j = 0; j < NO; j++) begin
                if (hold[j]) begin
                    check("hold_valid", out_valid[j], 1);
                    check("hold_data", lane(j), hold_data[j]);
                end
                if (!tb_en[j]) check("disabled_idle", out_valid[j], 0);
                if (out_valid[j] && out_ready[j]) begin
                    check("sb_nonempty", sb_q[j].size() != 0, 1);
                    if (sb_q[j].size() != 0) check("sb_data", lane(j), sb_q[j].pop_front());
                end
            end
            for (int i = 0; i < NI; i++) begin
                if (in_valid[i] && in_ready[i]) begin
                    for (int j = 0; j < NO; j++) begin
                        if (tb_en[j] && tb_src[j] == i) sb_q[j].push_back(in_data[i*DW +: DW]);
                    end
                end
            end
            if (cfg_we && cfg_ready) begin
                for (int j = 0; j < NO; j++) begin
                    tb_src[j] = int'(cfg_src[j*SW +: SW]);
                    tb_en[j]  = cfg_en[j];
                end
            end
            for (int j = 0; j < NO; j++) begin
                hold[j]      = out_valid[j] && !out_ready[j];
                hold_data[j] = lane(j);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [DW-1:0] v);
        in_data[i*DW +: DW] = v;
    endtask

    // Called just after a rising edge; returns just after the apply edge.
    task automatic do_cfg(input logic [NO*SW-1:0] src, input logic [NO-1:0] en);
        bit done = 1'b0;
        cfg_src = src;
        cfg_en  = en;
        cfg_we  = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (cfg_ready) begin
                check("apply_in_ready", in_ready, 0);
                done = 1'b1;
            end else begin
                tick();
            end
        end
        check("cfg_applied", done, 1);
        tick();
        cfg_we = 1'b0;
    endtask

    function automatic int total_queued();
        int s = 0;
        for (int j = 0; j < NO; j++) s += sb_q[j].size();
        return s;
    endfunction

    logic [NO*SW-1:0] rot, bc3, half;
    logic [NI-1:0]    fired;

    initial begin
        for (int j = 0; j < NO; j++) begin
            rot[j*SW +: SW]  = SW'((j + 1) % NI);
            bc3[j*SW +: SW]  = SW'(3);
            half[j*SW +: SW] = SW'(j / 2);
        end
        rst = 1'b1; in_data = '0; in_valid = '0; out_ready = '1;
        cfg_src = '0; cfg_en = '0; cfg_we = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 8'hFF);
        tick();

        // Identity passthrough, sustained one beat per cycle
        in_valid = 8'hFF;
        for (int c = 0; c < 16; c++) begin
            for (int i = 0; i < NI; i++) set_lane(i, DW'(16'h1000 + i + 16 * c));
            @(negedge clk);
            check("id_in_ready", in_ready, 8'hFF);
            if (c > 0) check("id_out_valid", out_valid, 8'hFF);
            if (c == 1) for (int j = 0; j < NO; j++) check("id_lane", lane(j), 16'h1000 + j);
            tick();
        end
        in_valid = '0;
        tick();

        // Config while busy: output 2 stalled
        out_ready = 8'hFB; in_valid = 8'h04; set_lane(2, 16'h0222);
        tick();
        in_valid = '0; cfg_src = rot; cfg_en = 8'h7F; cfg_we = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("busy_out_valid", out_valid, 8'h04);
            check("busy_cfg_ready", cfg_ready, 0);
            check("busy_flag", busy, 1);
            check("busy_in_ready", in_ready, 8'hFB);
            tick();
        end
        out_ready = 8'hFF;
        @(negedge clk);
        check("drain_cfg_ready", cfg_ready, 0);
        tick();
        @(negedge clk);
        check("apply_cfg_ready", cfg_ready, 1);
        check("apply_in_ready0", in_ready, 0);
        tick();
        cfg_we = 1'b0;

        // Rotate routing, input 0 unselected
        in_valid = 8'hFF;
        for (int i = 0; i < NI; i++) set_lane(i, DW'(8'hA0 + i));
        @(negedge clk);
        check("rot_in_ready", in_ready, 8'hFE);
        tick();
        in_valid = '0;
        @(negedge clk);
        check("rot_out_valid", out_valid, 8'h7F);
        for (int j = 0; j < NO - 1; j++) check("rot_lane", lane(j), 16'hA0 + (j + 1) % 8);
        tick();

        // Broadcast fork with output 5 stalled
        do_cfg(bc3, 8'hFF);
        out_ready = 8'hDF; in_valid = 8'h08; set_lane(3, 16'h0033);
        @(negedge clk);
        check("bc_first_ready", in_ready, 8'h08);
        tick();
        set_lane(3, 16'hBEEF);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bc_blocked", in_ready, 0);
            check("bc_out_valid", out_valid, (k == 0) ? 8'hFF : 8'h20);
            check("bc_lane5", lane(5), 16'h0033);
            tick();
        end
        out_ready = 8'hFF;
        @(negedge clk);
        check("bc_release", in_ready, 8'h08);
        tick();
        in_valid = '0;
        @(negedge clk);
        check("bc_all_valid", out_valid, 8'hFF);
        for (int j = 0; j < NO; j++) check("bc_lane", lane(j), 16'hBEEF);
        tick();
        @(negedge clk);
        check("bc_once", out_valid, 0);
        tick();

        // Simultaneous cfg_we and in_valid, then random backpressure on a fork map
        in_valid = 8'hFF;
        for (int i = 0; i < NI; i++) set_lane(i, DW'($urandom));
        do_cfg(half, 8'hFF);
        fired = '0;
        for (int c = 0; c < 1000; c++) begin
            out_ready = NO'($urandom);
            for (int i = 0; i < NI; i++) begin
                if (!in_valid[i] || fired[i]) begin
                    in_valid[i] = 1'($urandom_range(0, 1));
                    set_lane(i, DW'($urandom));
                end
            end
            @(negedge clk);
            fired = in_valid & in_ready;
            tick();
        end
        in_valid = '0; out_ready = 8'hFF;
        tick(); tick(); tick();
        @(negedge clk);
        check("rand_drained", total_queued(), 0);
        tick();

        // Reset mid-stream with every output valid
        do_cfg(rot, 8'hFF);
        out_ready = '0; in_valid = 8'hFF;
        for (int i = 0; i < NI; i++) set_lane(i, DW'(16'h7000 + i));
        tick();
        in_valid = '0;
        @(negedge clk);
        check("pre_rst_valid", out_valid, 8'hFF);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_cfg_ready", cfg_ready, 1);
        check("mid_rst_in_ready", in_ready, 8'hFF);
        tick();
        out_ready = 8'hFF; in_valid = 8'hFF;
        for (int i = 0; i < NI; i++) set_lane(i, DW'(16'h5000 + i));
        tick();
        in_valid = '0;
        @(negedge clk);
        check("post_rst_valid", out_valid, 8'hFF);
        for (int j = 0; j < NO; j++) check("post_rst_lane", lane(j), 16'h5000 + j);
        tick(); tick();
        @(negedge clk);
        check("final_drained", total_queued(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
